// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared states, size codes and default parameters for the
// fetch/data memory port arbiter.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;
   localparam logic [1:0] SIZE_FETCH = SIZE_D;
   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// arb_select: grant decision between fetch and data requesters; data wins unless
// both request and data was the last one granted.
module arb_select (
   input  logic i_req,
   input  logic d_req,
   input  logic last_d,
   output logic grant_d
);
   assign grant_d = d_req && !(i_req && last_d);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (fetch/data) single memory port with timeout abort.
// Define MEM_PORT_ARB_RR_EN for round-robin on simultaneous requests; default is data priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [1:0]        d_size,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [1:0]        m_size,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,
   output logic              busy,
   output logic              timeout_err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              win_d_q, win_d_d, to_q, to_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rd;
   logic [1:0]        size_q, size_d;
   logic              grant_d, last_d;

`ifdef MEM_PORT_ARB_RR_EN
   logic last_d_q;
   always_ff @(posedge clock) begin
      if (!reset) last_d_q <= 1'b0;
      else if (state_q == IDLE && (i_req || d_req)) last_d_q <= grant_d;
   end
   assign last_d = last_d_q;
`else
   assign last_d = 1'b0;
`endif

   arb_select u_arb (.i_req(i_req), .d_req(d_req), .last_d(last_d), .grant_d(grant_d));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      win_d_d   = win_d_q;
      to_d      = to_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      rd        = (m_ready && !we_q) ? m_rdata : '0;
      case (state_q)
         IDLE: if (i_req || d_req) begin
            state_d = ACCESS;
            cnt_d   = '0;
            to_d    = 1'b0;
            win_d_d = grant_d;
            we_d    = grant_d && d_we;
            addr_d  = grant_d ? d_addr : i_addr;
            wdata_d = grant_d ? d_wdata : '0;
            size_d  = grant_d ? d_size : SIZE_FETCH;
         end
         ACCESS: if (m_ready || cnt_q == CW'(TIMEOUT - 1)) begin
            // m_ready on the final allowed cycle still counts as success
            state_d = DONE;
            to_d    = !m_ready;
            if (win_d_q) d_rdata_d = rd;
            else i_rdata_d = rd;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         win_d_q   <= 1'b0;
         to_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         win_d_q   <= win_d_d;
         to_q      <= to_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign m_req       = state_q == ACCESS;
   assign m_we        = we_q;
   assign m_addr      = addr_q;
   assign m_wdata     = wdata_q;
   assign m_size      = size_q;
   assign i_ack       = state_q == DONE && !win_d_q;
   assign d_ack       = state_q == DONE && win_d_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign busy        = state_q != IDLE;
   assign timeout_err = state_q == DONE && to_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
   localparam int TO = 15;

   logic        clock = 1'b0, reset = 1'b0;
   logic        i_req = 0, d_req = 0, d_we = 0, m_ready = 0;
   logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
   logic [1:0]  d_size = 0;
   logic [63:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic        i_ack, d_ack, m_req, m_we, busy, timeout_err;
   logic [1:0]  m_size;

   int          n_cmp = 0, n_bad = 0;
   logic        exp_last_d = 1'b0;
   logic [63:0] exp_ir = 0, exp_dr = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
      .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic model_grant_d(input logic ir, input logic dr);
`ifdef MEM_PORT_ARB_RR_EN
      return (ir && dr) ? !exp_last_d : dr;
`else
      return dr;
`endif
   endfunction

   task automatic test_reset;
      reset = 1'b0; i_req = 1; d_req = 1; m_ready = 1;
      tick; tick;
      n_cmp++;
      if ({m_req, m_we, i_ack, d_ack, busy, timeout_err, m_size} !== 8'h0 ||
          m_addr !== 0 || m_wdata !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
         n_bad++;
         $display("FAIL reset_state: ctl=%b size=%b addr=%0h wdata=%0h ir=%0h dr=%0h want all zero",
                  {m_req, m_we, i_ack, d_ack, busy, timeout_err}, m_size, m_addr, m_wdata, i_rdata, d_rdata);
      end
      i_req = 0; d_req = 0; m_ready = 0; reset = 1'b1;
      exp_ir = 0; exp_dr = 0; exp_last_d = 0;
      tick;
   endtask

   task automatic test_fetch;
      i_req = 1; i_addr = 64'h100; m_ready = 1; m_rdata = 64'hDEAD;
      tick;
      n_cmp++;
      if (m_req !== 1 || m_addr !== 64'h100 || m_we !== 0 || m_size !== 2'b11 || m_wdata !== 0) begin
         n_bad++;
         $display("FAIL fetch_issue: req=%b addr=%0h we=%b size=%b wdata=%0h want 1/100/0/11/0",
                  m_req, m_addr, m_we, m_size, m_wdata);
      end
      tick;
      n_cmp++;
      if (i_ack !== 1 || d_ack !== 0 || i_rdata !== 64'hDEAD || m_req !== 0 || timeout_err !== 0) begin
         n_bad++;
         $display("FAIL fetch_ack: iack=%b dack=%b rdata=%0h mreq=%b to=%b want 1/0/dead/0/0",
                  i_ack, d_ack, i_rdata, m_req, timeout_err);
      end
      i_req = 0; m_ready = 0; m_rdata = 64'h1234;
      tick;
      n_cmp++;
      if (busy !== 0 || i_ack !== 0 || i_rdata !== 64'hDEAD) begin
         n_bad++;
         $display("FAIL fetch_hold: busy=%b iack=%b rdata=%0h want 0/0/dead", busy, i_ack, i_rdata);
      end
      exp_ir = 64'hDEAD; exp_last_d = 0;
   endtask

   task automatic test_store;
      d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'h55; d_size = 2'b10; m_rdata = 64'hCAFE;
      tick;
      for (int k = 0; k < 4; k++) begin
         m_ready = (k == 3);
         n_cmp++;
         if (m_req !== 1 || m_we !== 1 || m_wdata !== 64'h55 || m_addr !== 64'h40 || m_size !== 2'b10) begin
            n_bad++;
            $display("FAIL store_hold[%0d]: req=%b we=%b wdata=%0h addr=%0h size=%b want 1/1/55/40/10",
                     k, m_req, m_we, m_wdata, m_addr, m_size);
         end
         tick;
      end
      n_cmp++;
      if (d_ack !== 1 || i_ack !== 0 || d_rdata !== 0 || m_req !== 0) begin
         n_bad++;
         $display("FAIL store_ack: dack=%b iack=%b rdata=%0h mreq=%b want 1/0/0/0", d_ack, i_ack, d_rdata, m_req);
      end
      d_req = 0; d_we = 0; m_ready = 0;
      tick;
      n_cmp++;
      if (d_ack !== 0 || busy !== 0) begin
         n_bad++;
         $display("FAIL store_single_ack: dack=%b busy=%b want 0/0", d_ack, busy);
      end
      exp_dr = 0; exp_last_d = 1;
   endtask

   task automatic test_priority;
      logic w;
      reset = 0; tick; reset = 1;
      exp_ir = 0; exp_dr = 0; exp_last_d = 0;
      i_req = 1; d_req = 1; d_we = 0; i_addr = 64'h1000; d_addr = 64'h2000; d_size = 2'b01; m_ready = 1;
      for (int t = 0; t < 4; t++) begin
         w = model_grant_d(1'b1, 1'b1);
         m_rdata = 64'hA000 + 64'(t);
         tick;
         n_cmp++;
         if (m_addr !== (w ? 64'h2000 : 64'h1000)) begin
            n_bad++;
            $display("FAIL prio_addr[%0d]: got %0h want %0h", t, m_addr, w ? 64'h2000 : 64'h1000);
         end
         tick;
         n_cmp++;
         if (d_ack !== w || i_ack !== !w || (w ? d_rdata : i_rdata) !== 64'hA000 + 64'(t)) begin
            n_bad++;
            $display("FAIL prio_ack[%0d]: dack=%b iack=%b want dack=%b iack=%b", t, d_ack, i_ack, w, !w);
         end
         if (w) exp_dr = 64'hA000 + 64'(t);
         else exp_ir = 64'hA000 + 64'(t);
         exp_last_d = w;
         tick;
      end
      i_req = 0; d_req = 0; m_ready = 0;
      tick;
   endtask

   task automatic test_timeout;
      int k;
      logic [63:0] e;
      for (int v = 0; v < 2; v++) begin
         k = 0;
         d_req = 1; d_we = 0; d_addr = 64'h80; d_size = 2'b10; m_rdata = 64'hBEEF; m_ready = 0;
         tick;
         while (m_req === 1'b1 && k < TO + 3) begin
            m_ready = (v == 1 && k == TO - 1);
            k++;
            tick;
         end
         e = (v == 0) ? 64'h0 : 64'hBEEF;
         n_cmp++;
         if (k !== TO) begin
            n_bad++;
            $display("FAIL timeout_len[%0d]: m_req cycles %0d want %0d", v, k, TO);
         end
         n_cmp++;
         if (d_ack !== 1 || timeout_err !== (v == 0) || d_rdata !== e) begin
            n_bad++;
            $display("FAIL timeout_ack[%0d]: dack=%b err=%b rdata=%0h want 1/%0b/%0h",
                     v, d_ack, timeout_err, d_rdata, v == 0, e);
         end
         d_req = 0; m_ready = 0;
         tick;
         n_cmp++;
         if (busy !== 0 || timeout_err !== 0 || d_ack !== 0) begin
            n_bad++;
            $display("FAIL timeout_after[%0d]: busy=%b err=%b dack=%b want 0/0/0", v, busy, timeout_err, d_ack);
         end
         exp_dr = e; exp_last_d = 1;
      end
   endtask

   task automatic test_reset_mid;
      i_req = 1; i_addr = 64'h300; m_ready = 0;
      tick; tick;
      reset = 0; i_req = 0;
      tick;
      n_cmp++;
      if (m_req !== 0 || busy !== 0 || i_ack !== 0 || d_ack !== 0) begin
         n_bad++;
         $display("FAIL reset_mid: mreq=%b busy=%b iack=%b dack=%b want 0/0/0/0", m_req, busy, i_ack, d_ack);
      end
      reset = 1; exp_ir = 0; exp_dr = 0; exp_last_d = 0;
      tick;
      n_cmp++;
      if (i_ack !== 0 || busy !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_noack: iack=%b busy=%b want 0/0", i_ack, busy);
      end
      d_req = 1; d_we = 0; d_addr = 64'h88; d_size = 2'b00; m_ready = 1; m_rdata = 64'h7777;
      tick; tick;
      n_cmp++;
      if (d_ack !== 1 || d_rdata !== 64'h7777 || timeout_err !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_fresh: dack=%b rdata=%0h err=%b want 1/7777/0", d_ack, d_rdata, timeout_err);
      end
      d_req = 0; m_ready = 0; exp_dr = 64'h7777; exp_last_d = 1;
      tick;
   endtask

   task automatic test_drop;
      int k, extra;
      k = 0; extra = 0;
      i_req = 1; i_addr = 64'h500; m_ready = 0; m_rdata = 64'h4242;
      tick;
      i_req = 0;
      while (m_req === 1'b1 && k < TO + 3) begin
         m_ready = (k == 2);
         k++;
         tick;
      end
      n_cmp++;
      if (k !== 3 || i_ack !== 1 || i_rdata !== 64'h4242) begin
         n_bad++;
         $display("FAIL drop_ack: cycles=%0d iack=%b rdata=%0h want 3/1/4242", k, i_ack, i_rdata);
      end
      m_ready = 0;
      for (int c = 0; c < 4; c++) begin
         tick;
         extra += int'(m_req) + int'(i_ack) + int'(d_ack);
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++;
         $display("FAIL drop_no_reissue: extra activity %0d want 0", extra);
      end
      exp_ir = 64'h4242; exp_last_d = 0;
   endtask

   task automatic test_random;
      logic ir, dr, w, to;
      int lat, k;
      logic [63:0] rd, e, ea;
      logic [1:0] es;
      for (int n = 0; n < 60; n++) begin
         ir = 1'($urandom); dr = 1'($urandom);
         if (!ir && !dr) dr = 1;
         i_req = ir; d_req = dr; d_we = 1'($urandom);
         i_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
         d_wdata = {$urandom, $urandom}; d_size = 2'($urandom);
         lat = $urandom_range(0, TO + 1);
         w = model_grant_d(ir, dr);
         ea = w ? d_addr : i_addr;
         es = w ? d_size : 2'b11;
         to = lat >= TO;
         k = 0; rd = 0;
         tick;
         while (m_req === 1'b1 && k < TO + 3) begin
            n_cmp++;
            if (m_addr !== ea || m_size !== es || m_we !== (w && d_we) || m_wdata !== (w ? d_wdata : 64'h0)) begin
               n_bad++;
               $display("FAIL rand_fields[%0d]: addr=%0h size=%b we=%b want addr=%0h size=%b", n, m_addr, m_size, m_we, ea, es);
            end
            m_rdata = {$urandom, $urandom};
            m_ready = (k == lat);
            if (k == lat) rd = m_rdata;
            k++;
            tick;
         end
         e = (to || (w && d_we)) ? 64'h0 : rd;
         if (w) exp_dr = e;
         else exp_ir = e;
         exp_last_d = w;
         n_cmp++;
         if (k !== (to ? TO : lat + 1) || d_ack !== w || i_ack !== !w || timeout_err !== to) begin
            n_bad++;
            $display("FAIL rand_done[%0d]: cycles=%0d dack=%b iack=%b err=%b want %0d/%b/%b/%b",
                     n, k, d_ack, i_ack, timeout_err, to ? TO : lat + 1, w, !w, to);
         end
         n_cmp++;
         if (i_rdata !== exp_ir || d_rdata !== exp_dr) begin
            n_bad++;
            $display("FAIL rand_rdata[%0d]: ir=%0h dr=%0h want %0h/%0h", n, i_rdata, d_rdata, exp_ir, exp_dr);
         end
         i_req = 0; d_req = 0; m_ready = 0;
         tick;
      end
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_store;
      test_priority;
      test_timeout;
      test_reset_mid;
      test_drop;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: address width.
REQ-002 SHALL have parameter DATA_W, default 64: data width.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles without m_ready before abort.
REQ-004 SHALL have ports:
  clock  in  1  sole clock; all state updates on its rising edge.
  reset  in  1  synchronous, active-low.
  i_req  in  1  fetch request, held high until i_ack.
  i_addr  in  ADDR_W  fetch address.
  i_rdata  out  DATA_W  fetch read data, valid with i_ack.
  i_ack  out  1  fetch completion, one-cycle pulse.
  d_req  in  1  data request, held high until d_ack.
  d_we  in  1  1=store, 0=load.
  d_addr  in  ADDR_W  data address.
  d_wdata  in  DATA_W  store data.
  d_size  in  2  access size code, passed through unchanged.
  d_rdata  out  DATA_W  load data, valid with d_ack.
  d_ack  out  1  data completion, one-cycle pulse.
  m_req  out  1  memory request.
  m_we, m_addr, m_wdata, m_size  out  1/ADDR_W/DATA_W/2  latched transaction fields.
  m_rdata  in  DATA_W  memory read data.
  m_ready  in  1  memory completion, sampled only while m_req=1.
  busy  out  1  high whenever state is not IDLE.
  timeout_err  out  1  one-cycle pulse alongside the ack of an aborted transaction.

Function
REQ-005 SHALL implement three states: IDLE, ACCESS, DONE.
REQ-006 IDLE: with any request high, SHALL select a winner, latch its address, write enable, write data and size into registers, and go to ACCESS; with no request high, SHALL stay in IDLE.
REQ-007 Fetch transactions SHALL drive m_we=0, m_size=2'b11, m_wdata=0.
REQ-008 ACCESS: SHALL drive m_req=1 from the latched fields. On m_ready=1 it SHALL capture m_rdata and go to DONE.
REQ-009 DONE: SHALL pulse the winner's ack for exactly one cycle with its rdata valid, SHALL keep m_req=0, and SHALL go to IDLE.
REQ-010 Minimum latency: request high at cycle 0 gives m_req at cycle 1; m_ready at cycle 1 gives ack at cycle 2. Each transaction occupies at least 3 cycles.
REQ-011 rdata outputs SHALL hold their last value between acks. Store acks SHALL return zero rdata.
REQ-012 Timeout: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle while m_ready=0. When it reaches TIMEOUT, the arbiter SHALL go to DONE, ack with rdata=0, and pulse timeout_err.
REQ-013 m_ready arriving on the same cycle the count reaches TIMEOUT SHALL be treated as success, with no timeout_err.
REQ-014 A requester that drops req mid-transaction SHALL NOT abort the transaction; its ack SHALL still pulse.
REQ-015 Both acks SHALL NOT assert in the same cycle. m_req SHALL NOT assert in IDLE or DONE.
REQ-016 Arbitration with both requests high (default, macro undefined): d_req SHALL win.

Reset
REQ-017 While reset=0 at a clock edge, the block SHALL return to IDLE and clear the counter, the latched fields, both rdata registers, the last-winner flag, and all outputs to 0.
REQ-018 Reset mid-ACCESS SHALL drop m_req at the next edge and SHALL NOT generate an ack.

Configuration
REQ-019 Macro MEM_PORT_ARB_RR_EN: when defined, simultaneous requests SHALL alternate by last-winner flag: the requester not granted last wins. The flag resets to "fetch", so data wins first after reset.
REQ-020 Without MEM_PORT_ARB_RR_EN, data SHALL always win (fixed priority) and the flag SHALL be absent.

Structure
REQ-021 A shared package SHALL hold the state enumeration (IDLE/ACCESS/DONE), the size code constants, and the default width and TIMEOUT constants.
REQ-022 Arbitration decision SHALL be one sub-module, arb_select, taking i_req, d_req and the last-winner flag and producing the grant; everything else stays in the top module.

Verification
REQ-023 i_req=1, i_addr=0x100; m_ready high on the first m_req cycle, m_rdata=0xDEAD -> m_addr=0x100 at cycle 1; i_ack and i_rdata=0xDEAD at cycle 2.
REQ-024 d_req=1, d_we=1, d_addr=0x40, d_wdata=0x55; m_ready after 3 cycles -> m_we=1, m_wdata=0x55 held 4 cycles; then one d_ack with d_rdata=0.
REQ-025 i_req and d_req raised together, both held through 4 transactions -> default build: D,D,D,D. MEM_PORT_ARB_RR_EN build: D,I,D,I.
REQ-026 m_ready held 0, TIMEOUT=15 -> m_req high 15 cycles, then ack with rdata=0 and timeout_err=1 in the same cycle; a variant with m_ready arriving on cycle 15 -> normal ack, timeout_err=0.
REQ-027 reset=0 during the 2nd ACCESS cycle -> m_req=0, busy=0 next cycle; no ack; a fresh request afterwards completes normally.
REQ-028 i_req dropped after grant, m_ready after 2 cycles -> i_ack still pulses once; no second transaction is issued.
